// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the digital clock timekeeping core.
package clock_pkg;

    // Two packed BCD digits: tens in [7:4], units in [3:0].
    typedef logic [7:0] bcd8_t;

    // Counting mode of the timekeeping core.
    typedef enum logic {
        MODE_HOLD = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    localparam bcd8_t SEC_MAX  = 8'h59;
    localparam bcd8_t MIN_MAX  = 8'h59;
    localparam bcd8_t HOUR_MAX = 8'h23;

    // Both digits decimal and the value no larger than max. With decimal digits,
    // a plain binary compare orders BCD values correctly.
    function automatic logic bcd_valid(bcd8_t v, bcd8_t max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Successor of v in a BCD counter that wraps from max to 00.
    function automatic bcd8_t bcd_next(bcd8_t v, bcd8_t max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (00..MAX) with synchronous load.
// wrap is combinational so counters can be chained within one cycle.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd8_t MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       wrap
);

    assign wrap = inc && !load && (value == MAX);

    // Value register: load has priority over increment.
    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (inc)
            value <= bcd_next(value, MAX);
    end

endmodule

// File: rtl/time_counter.sv
// BCD hh:mm:ss timekeeping core (24-hour) driven by the divider's 1 Hz square wave.
// Holds the tick synchronizer/edge detect, load handshake, run/hold FSM and alarm.
// Optional alarm comparator built when TIME_COUNTER_ALARM_EN is defined.
module time_counter
    import clock_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       min_carry,
    output logic       hour_carry,
    output logic       day_wrap,
    output logic       set_err,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_arm,
    output logic       alarm_hit
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   tick_hist;
    logic                   tick;
    mode_e                  state, state_next;
    logic                   count_en;
    logic                   load_fire, load_ok, load_en;
    logic                   adv;
    logic                   s_wrap, m_wrap, h_wrap;

    // Synchronizer chain plus history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            tick_hist <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], tick_in};
            tick_hist <= sync[SYNC_STAGES-1];
        end
    end

    assign tick = sync[SYNC_STAGES-1] && !tick_hist;

    // Mode state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= MODE_HOLD;
        else
            state <= state_next;
    end

    // Mode next-state: follow run every cycle; only RUN lets ticks through.
    always_comb begin
        state_next = state;
        count_en   = 1'b0;
        case (state)
            MODE_RUN: begin
                count_en = 1'b1;
                if (!run)
                    state_next = MODE_HOLD;
            end
            MODE_HOLD: begin
                if (run)
                    state_next = MODE_RUN;
            end
            default: state_next = MODE_HOLD;
        endcase
    end

    assign load_fire = set_valid && set_ready;
    assign load_ok   = bcd_valid(set_hh, HOUR_MAX) && bcd_valid(set_mm, MIN_MAX)
                       && bcd_valid(set_ss, SEC_MAX);
    assign load_en   = load_fire && load_ok;
    // Any handshake (accepted or rejected) swallows a coincident tick.
    assign adv       = tick && count_en && !load_fire;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (adv),
        .load     (load_en),
        .load_val (set_ss),
        .value    (ss),
        .wrap     (s_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (s_wrap),
        .load     (load_en),
        .load_val (set_mm),
        .value    (mm),
        .wrap     (m_wrap)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      (m_wrap),
        .load     (load_en),
        .load_val (set_hh),
        .value    (hh),
        .wrap     (h_wrap)
    );

    // Registered one-cycle pulses and load-ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_ready  <= 1'b0;
            sec_pulse  <= 1'b0;
            min_carry  <= 1'b0;
            hour_carry <= 1'b0;
            day_wrap   <= 1'b0;
            set_err    <= 1'b0;
        end else begin
            set_ready  <= 1'b1;
            sec_pulse  <= adv;
            min_carry  <= s_wrap;
            hour_carry <= m_wrap;
            day_wrap   <= h_wrap;
            set_err    <= load_fire && !load_ok;
        end
    end

`ifdef TIME_COUNTER_ALARM_EN
    bcd8_t next_mm, next_hh;
    logic  alarm_match;

    // Predict the post-tick hh:mm so the hit pulse aligns with the new time.
    always_comb begin
        next_mm = mm;
        next_hh = hh;
        if (ss == SEC_MAX) begin
            next_mm = bcd_next(mm, MIN_MAX);
            if (mm == MIN_MAX)
                next_hh = bcd_next(hh, HOUR_MAX);
        end
        alarm_match = adv && alarm_arm && (ss == SEC_MAX)
                      && (next_mm == alarm_mm) && (next_hh == alarm_hh);
    end

    // Alarm hit pulse register.
    always_ff @(posedge clk) begin
        if (rst)
            alarm_hit <= 1'b0;
        else
            alarm_hit <= alarm_match;
    end
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_hh, alarm_mm, alarm_arm};
    assign alarm_hit    = 1'b0;
`endif

endmodule
